// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the per-stage control codes, the issue codes shown on the display,
// the controller state codes and the default highest legal fetch address.
package pipeline_hazard_controller_pkg;

    // Per-stage pipeline register control, two bits per stage.
    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        HOLD   = 2'b01,
        NO_OP  = 2'b10
    } stage_ctrl_t;

    // Issue currently being handled, exported for display.
    typedef enum logic [2:0] {
        ISSUE_NONE  = 3'd0,
        ISSUE_DATA  = 3'd1,
        ISSUE_PAUSE = 3'd2,
        ISSUE_UART  = 3'd3,
        ISSUE_IRQ   = 3'd4
    } issue_t;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXECUTE   = 2'd1,
        HAZARD    = 2'd2,
        INTERRUPT = 2'd3
    } state_t;

    // Highest legal instruction address; fetches above it mean the program
    // image must be rewritten over the UART.
    localparam logic [31:0] PC_MAX_VALUE = 32'h0000_0FFC;

endpackage

// File: rtl/pipeline_hazard_controller_irq_priority_encoder.sv
// Fixed-priority interrupt arbiter.
// Ports:
//   req   in  IRQ_CNT  level requests, bit 0 has the highest priority
//   grant out IRQ_CNT  one-hot grant of the lowest-index requester, 0 if none
module irq_priority_encoder #(
    parameter int IRQ_CNT = 2
) (
    input  logic [IRQ_CNT-1:0] req,
    output logic [IRQ_CNT-1:0] grant
);

    // NOTE: grant gets a default before the loop so every path assigns it
    // and no latch is inferred.
    always_comb begin
        grant = '0;
        // Scan from the top down so the lowest set index wins last.
        for (int i = IRQ_CNT - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller.
// Watches decode/execute/memory stage information, the fetch address, a user
// pause request and interrupt requests, and drives per-stage hold/flush
// controls, the UART rewrite handshake and interrupt servicing. All
// registered outputs change on the falling edge of clk.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   uart_complete / uart_disable  UART rewrite done / UART held in reset
//   reg_1_valid, reg_2_valid, branch_instruction, id_reg_1_idx, id_reg_2_idx
//                                 ID-stage source operands
//   ex_mem_read_enable, ex_reg_write_enable, ex_no_op, ex_reg_dest_idx
//                                 EX-stage destination info
//   mem_reg_write_enable, mem_no_op, mem_reg_dest_idx
//                                 MEM-stage destination info
//   pc_next                       next fetch address
//   cpu_pause                     user pause request (level)
//   irq_req / irq_done / irq_active
//                                 interrupt request, completion, serviced source
//   pc_reset                      one-cycle pulse restarting the pc at 0
//   hazard_control                2 bits per stage, IF stage at [1:0]
//   issue_type                    current issue code
//   stall_count                   saturating count of stalled cycles
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int                STAGE_CNT  = 5,
    parameter int                REG_ADDR_W = 5,
    parameter int                ISA_W      = 32,
    parameter logic [ISA_W-1:0]  PC_MAX     = ISA_W'(PC_MAX_VALUE),
    parameter int                IRQ_CNT    = 2,
    parameter int                CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_complete,
    output logic                     uart_disable,
    input  logic                     reg_1_valid,
    input  logic                     reg_2_valid,
    input  logic                     branch_instruction,
    input  logic                     ex_mem_read_enable,
    input  logic                     ex_reg_write_enable,
    input  logic                     ex_no_op,
    input  logic                     mem_reg_write_enable,
    input  logic                     mem_no_op,
    input  logic [REG_ADDR_W-1:0]    id_reg_1_idx,
    input  logic [REG_ADDR_W-1:0]    id_reg_2_idx,
    input  logic [REG_ADDR_W-1:0]    ex_reg_dest_idx,
    input  logic [REG_ADDR_W-1:0]    mem_reg_dest_idx,
    input  logic [ISA_W-1:0]         pc_next,
    input  logic                     cpu_pause,
    input  logic [IRQ_CNT-1:0]       irq_req,
    input  logic [IRQ_CNT-1:0]       irq_done,
    output logic [IRQ_CNT-1:0]       irq_active,
    output logic                     pc_reset,
    output logic [2*STAGE_CNT-1:0]   hazard_control,
    output logic [2:0]               issue_type,
    output logic [CNT_W-1:0]         stall_count
);

    localparam logic [2*STAGE_CNT-1:0] ALL_NORMAL = {STAGE_CNT{NORMAL}};
    localparam logic [2*STAGE_CNT-1:0] ALL_NO_OP  = {STAGE_CNT{NO_OP}};

    state_t             state_q;
    issue_t             issue_q;
    logic [IRQ_CNT-1:0] irq_grant;
    logic               ex_conflict;
    logic               mem_conflict;
    logic               data_hazard;
    logic               uart_hazard;

    // A stage conflicts when it will write a real (nonzero) register that an
    // ID-stage operand actually reads; r0 is hardwired and never forwarded.
    assign ex_conflict = ex_reg_write_enable && !ex_no_op && (ex_reg_dest_idx != '0)
                         && ((reg_1_valid && (id_reg_1_idx == ex_reg_dest_idx))
                          || (reg_2_valid && (id_reg_2_idx == ex_reg_dest_idx)));

    assign mem_conflict = mem_reg_write_enable && !mem_no_op && (mem_reg_dest_idx != '0)
                          && ((reg_1_valid && (id_reg_1_idx == mem_reg_dest_idx))
                           || (reg_2_valid && (id_reg_2_idx == mem_reg_dest_idx)));

    // Branches resolve in ID so they need both results; other instructions
    // only stall on a load whose data is not yet available.
    assign data_hazard = (branch_instruction && (ex_conflict || mem_conflict))
                         || (ex_mem_read_enable && ex_conflict);

    assign uart_hazard = (pc_next > PC_MAX);

    assign issue_type = issue_q;

    irq_priority_encoder #(
        .IRQ_CNT (IRQ_CNT)
    ) u_irq_priority_encoder (
        .req   (irq_req),
        .grant (irq_grant)
    );

    // Falling-edge update gives the rising-edge pipeline registers a full
    // half cycle of settled controls.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            issue_q        <= ISSUE_NONE;
            uart_disable   <= 1'b1;
            pc_reset       <= 1'b0;
            hazard_control <= ALL_NORMAL;
            irq_active     <= '0;
            stall_count    <= '0;
        end else begin
            pc_reset <= 1'b0;

            if ((state_q == HAZARD || state_q == INTERRUPT) && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    state_q <= EXECUTE;
                end

                EXECUTE: begin
                    if (data_hazard) begin
                        hazard_control[1:0] <= HOLD;
                        hazard_control[3:2] <= HOLD;
                        hazard_control[5:4] <= NO_OP;
                        issue_q             <= ISSUE_DATA;
                        state_q             <= HAZARD;
                    end else if (cpu_pause || uart_hazard) begin
                        hazard_control[1:0] <= NO_OP;
                        uart_disable        <= 1'b0;
                        issue_q             <= cpu_pause ? ISSUE_PAUSE : ISSUE_UART;
                        state_q             <= HAZARD;
                    end else if (|irq_req) begin
                        irq_active     <= irq_grant;
                        hazard_control <= ALL_NO_OP;
                        issue_q        <= ISSUE_IRQ;
                        state_q        <= INTERRUPT;
                    end
                end

                HAZARD: begin
                    case (issue_q)
                        ISSUE_DATA: begin
                            if (!data_hazard) begin
                                hazard_control[5:0] <= {NORMAL, NORMAL, NORMAL};
                                issue_q             <= ISSUE_NONE;
                                state_q             <= EXECUTE;
                            end
                        end
                        ISSUE_UART, ISSUE_PAUSE: begin
                            // A pause arriving during a rewrite takes over, so
                            // the CPU stays stopped until the user releases it.
                            if (cpu_pause) begin
                                issue_q <= ISSUE_PAUSE;
                            end else if (uart_complete) begin
                                uart_disable        <= 1'b1;
                                hazard_control[1:0] <= NORMAL;
                                pc_reset            <= 1'b1;
                                issue_q             <= ISSUE_NONE;
                                state_q             <= EXECUTE;
                            end
                        end
                        default: begin
                            issue_q <= ISSUE_NONE;
                            state_q <= EXECUTE;
                        end
                    endcase
                end

                INTERRUPT: begin
                    // Only the source being serviced can end the interrupt.
                    if (|(irq_done & irq_active)) begin
                        hazard_control <= ALL_NORMAL;
                        irq_active     <= '0;
                        issue_q        <= ISSUE_NONE;
                        state_q        <= EXECUTE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed testbench for pipeline_hazard_controller (CNT_W=4 so saturation
// is reachable quickly). Inputs change 1 ns after a falling edge; outputs are
// sampled 1 ns after the falling edge that updates them.
module tb_pipeline_hazard_controller;

    localparam int STAGE_CNT  = 5;
    localparam int REG_ADDR_W = 5;
    localparam int ISA_W      = 32;
    localparam int IRQ_CNT    = 2;
    localparam int CNT_W      = 4;

    localparam logic [31:0] HC_NORMAL = 32'h000;
    localparam logic [31:0] HC_DATA   = 32'h025;  // stage2 NO_OP, stage1/0 HOLD
    localparam logic [31:0] HC_IF_NOP = 32'h002;  // stage0 NO_OP
    localparam logic [31:0] HC_ALLNOP = 32'h2AA;  // every stage NO_OP

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   uart_complete;
    logic                   uart_disable;
    logic                   reg_1_valid, reg_2_valid, branch_instruction;
    logic                   ex_mem_read_enable, ex_reg_write_enable, ex_no_op;
    logic                   mem_reg_write_enable, mem_no_op;
    logic [REG_ADDR_W-1:0]  id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx, mem_reg_dest_idx;
    logic [ISA_W-1:0]       pc_next;
    logic                   cpu_pause;
    logic [IRQ_CNT-1:0]     irq_req, irq_done, irq_active;
    logic                   pc_reset;
    logic [2*STAGE_CNT-1:0] hazard_control;
    logic [2:0]             issue_type;
    logic [CNT_W-1:0]       stall_count;

    int n_checks = 0;
    int n_passed = 0;

    pipeline_hazard_controller #(
        .STAGE_CNT  (STAGE_CNT),
        .REG_ADDR_W (REG_ADDR_W),
        .ISA_W      (ISA_W),
        .PC_MAX     (32'h0000_0FFC),
        .IRQ_CNT    (IRQ_CNT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .uart_complete        (uart_complete),
        .uart_disable         (uart_disable),
        .reg_1_valid          (reg_1_valid),
        .reg_2_valid          (reg_2_valid),
        .branch_instruction   (branch_instruction),
        .ex_mem_read_enable   (ex_mem_read_enable),
        .ex_reg_write_enable  (ex_reg_write_enable),
        .ex_no_op             (ex_no_op),
        .mem_reg_write_enable (mem_reg_write_enable),
        .mem_no_op            (mem_no_op),
        .id_reg_1_idx         (id_reg_1_idx),
        .id_reg_2_idx         (id_reg_2_idx),
        .ex_reg_dest_idx      (ex_reg_dest_idx),
        .mem_reg_dest_idx     (mem_reg_dest_idx),
        .pc_next              (pc_next),
        .cpu_pause            (cpu_pause),
        .irq_req              (irq_req),
        .irq_done             (irq_done),
        .irq_active           (irq_active),
        .pc_reset             (pc_reset),
        .hazard_control       (hazard_control),
        .issue_type           (issue_type),
        .stall_count          (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_decode();
        reg_1_valid          = 1'b0;
        reg_2_valid          = 1'b0;
        branch_instruction   = 1'b0;
        ex_mem_read_enable   = 1'b0;
        ex_reg_write_enable  = 1'b0;
        ex_no_op             = 1'b0;
        mem_reg_write_enable = 1'b0;
        mem_no_op            = 1'b0;
        id_reg_1_idx         = '0;
        id_reg_2_idx         = '0;
        ex_reg_dest_idx      = '0;
        mem_reg_dest_idx     = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_issue"},  32'(issue_type),     32'd0);
        check({tag, "_udis"},   32'(uart_disable),   32'd1);
        check({tag, "_pcrst"},  32'(pc_reset),       32'd0);
        check({tag, "_hc"},     32'(hazard_control), HC_NORMAL);
        check({tag, "_irq"},    32'(irq_active),     32'd0);
        check({tag, "_stall"},  32'(stall_count),    32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        uart_complete = 1'b0;
        pc_next       = '0;
        cpu_pause     = 1'b0;
        irq_req       = '0;
        irq_done      = '0;
        clear_decode();

        #12;
        check_reset_values("reset");
        rst = 1'b0;
        tick();  // IDLE -> EXECUTE
        check("exec_issue", 32'(issue_type), 32'd0);

        // r0 is never a hazard, even for a branch behind a load.
        ex_reg_write_enable = 1'b1; ex_mem_read_enable = 1'b1; ex_reg_dest_idx = 5'd0;
        reg_1_valid = 1'b1; id_reg_1_idx = 5'd0; branch_instruction = 1'b1;
        tick();
        check("r0_issue", 32'(issue_type),     32'd0);
        check("r0_hc",    32'(hazard_control), HC_NORMAL);

        // Load into r5 but operand not valid: no hazard.
        clear_decode();
        ex_reg_write_enable = 1'b1; ex_mem_read_enable = 1'b1; ex_reg_dest_idx = 5'd5;
        reg_1_valid = 1'b0; id_reg_1_idx = 5'd5;
        tick();
        check("invalid_src_issue", 32'(issue_type), 32'd0);

        // Load-use on r5: one hazard cycle.
        reg_1_valid = 1'b1;
        tick();
        check("load_use_issue", 32'(issue_type),     32'd1);
        check("load_use_hc",    32'(hazard_control), HC_DATA);
        clear_decode();
        tick();
        check("load_use_rel_hc",    32'(hazard_control), HC_NORMAL);
        check("load_use_rel_issue", 32'(issue_type),     32'd0);
        check("load_use_stall",     32'(stall_count),    32'd1);

        // MEM conflict without a branch is forwarded, no stall.
        mem_reg_write_enable = 1'b1; mem_reg_dest_idx = 5'd3; reg_2_valid = 1'b1; id_reg_2_idx = 5'd3;
        tick();
        check("mem_nobranch_issue", 32'(issue_type), 32'd0);
        // Same conflict with a branch stalls.
        branch_instruction = 1'b1;
        tick();
        check("mem_branch_issue", 32'(issue_type), 32'd1);
        clear_decode();
        tick();
        check("mem_branch_rel_issue", 32'(issue_type),  32'd0);
        check("mem_branch_stall",     32'(stall_count), 32'd2);

        // pc_next at PC_MAX is legal.
        pc_next = 32'h0000_0FFC;
        tick();
        check("pcmax_issue", 32'(issue_type), 32'd0);
        // PC_MAX+4 triggers a UART rewrite.
        pc_next = 32'h0000_1000;
        tick();
        check("uart_issue", 32'(issue_type),     32'd3);
        check("uart_udis",  32'(uart_disable),   32'd0);
        check("uart_hc",    32'(hazard_control), HC_IF_NOP);
        pc_next = '0;
        tick();
        check("uart_wait_issue", 32'(issue_type), 32'd3);
        uart_complete = 1'b1;
        tick();
        check("uart_done_pcrst", 32'(pc_reset),       32'd1);
        check("uart_done_udis",  32'(uart_disable),   32'd1);
        check("uart_done_issue", 32'(issue_type),     32'd0);
        check("uart_done_hc",    32'(hazard_control), HC_NORMAL);
        uart_complete = 1'b0;
        tick();
        check("uart_pcrst_pulse", 32'(pc_reset),    32'd0);
        check("uart_stall",       32'(stall_count), 32'd4);

        // Pause during UART upgrades; completion with pause high is ignored.
        pc_next = 32'h0000_1000;
        tick();
        check("up_uart_issue", 32'(issue_type), 32'd3);
        pc_next   = '0;
        cpu_pause = 1'b1;
        tick();
        check("up_pause_issue", 32'(issue_type), 32'd2);
        uart_complete = 1'b1;
        tick();
        check("up_hold_issue", 32'(issue_type), 32'd2);
        check("up_hold_pcrst", 32'(pc_reset),   32'd0);
        cpu_pause = 1'b0;
        tick();
        check("up_done_issue", 32'(issue_type),   32'd0);
        check("up_done_pcrst", 32'(pc_reset),     32'd1);
        check("up_done_udis",  32'(uart_disable), 32'd1);
        uart_complete = 1'b0;
        tick();
        check("up_stall", 32'(stall_count), 32'd7);

        // Two interrupt sources: bit 0 first; foreign irq_done ignored.
        irq_req = 2'b11;
        tick();
        check("irq_active0", 32'(irq_active),     32'h1);
        check("irq_hc",      32'(hazard_control), HC_ALLNOP);
        check("irq_issue",   32'(issue_type),     32'd4);
        irq_done = 2'b10;
        tick();
        check("irq_ignore_active", 32'(irq_active), 32'h1);
        check("irq_ignore_issue",  32'(issue_type), 32'd4);
        irq_done = 2'b01;
        irq_req  = 2'b10;
        tick();
        check("irq_exit_active", 32'(irq_active),     32'h0);
        check("irq_exit_hc",     32'(hazard_control), HC_NORMAL);
        check("irq_exit_issue",  32'(issue_type),     32'd0);
        irq_done = 2'b00;
        tick();
        check("irq_active1", 32'(irq_active), 32'h2);
        irq_done = 2'b10;
        irq_req  = 2'b00;
        tick();
        irq_done = 2'b00;
        check("irq1_exit_active", 32'(irq_active),  32'h0);
        check("irq_stall",        32'(stall_count), 32'd10);

        // Priority: data beats pause and IRQ; then pause beats IRQ.
        ex_reg_write_enable = 1'b1; ex_mem_read_enable = 1'b1; ex_reg_dest_idx = 5'd7;
        reg_2_valid = 1'b1; id_reg_2_idx = 5'd7;
        cpu_pause = 1'b1;
        irq_req   = 2'b01;
        tick();
        check("prio_data_issue", 32'(issue_type), 32'd1);
        clear_decode();
        tick();
        check("prio_data_rel", 32'(issue_type), 32'd0);
        tick();
        check("prio_pause_issue", 32'(issue_type), 32'd2);
        check("prio_pause_irq",   32'(irq_active), 32'h0);
        cpu_pause     = 1'b0;
        irq_req       = 2'b00;
        uart_complete = 1'b1;
        tick();
        uart_complete = 1'b0;
        check("prio_pause_done", 32'(issue_type), 32'd0);

        // Long interrupt saturates the 4-bit counter, then async reset.
        irq_req = 2'b01;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall",  32'(stall_count), 32'd15);
        check("sat_active", 32'(irq_active),  32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midirq_reset");
        irq_req = 2'b00;
        #10;
        rst = 1'b0;
        tick();
        check("post_reset_issue", 32'(issue_type), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter STAGE_CNT, default 5; number of pipeline stage registers controlled, minimum 3.
REQ-002 SHALL have parameter REG_ADDR_W, default 5; width of register indices.
REQ-003 SHALL have parameter ISA_W, default 32; width of pc_next.
REQ-004 SHALL have parameter PC_MAX, default `PC_MAX_VALUE; highest legal instruction address.
REQ-005 SHALL have parameter IRQ_CNT, default 2; number of interrupt sources, 1..8.
REQ-006 SHALL have parameter CNT_W, default 16; stall counter width.
REQ-007 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- uart_complete  in  1  UART rewrite finished.
- uart_disable  out  1  1 = UART held in reset, memories in CPU mode.
- reg_1_valid, reg_2_valid, branch_instruction  in  1 each  ID-stage decode info.
- ex_mem_read_enable, ex_reg_write_enable, ex_no_op  in  1 each  EX-stage info.
- mem_reg_write_enable, mem_no_op  in  1 each  MEM-stage info.
- id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx, mem_reg_dest_idx  in  REG_ADDR_W each  register indices.
- pc_next  in  ISA_W  next fetch address.
- cpu_pause  in  1  user pause request, level.
- irq_req  in  IRQ_CNT  level interrupt requests; bit 0 highest priority.
- irq_done  in  IRQ_CNT  per-source completion pulse.
- irq_active  out  IRQ_CNT  one-hot source being serviced.
- pc_reset  out  1  one-cycle pulse restarting pc at 0.
- hazard_control  out  2*STAGE_CNT  per-stage control, stage 0 (IF) at bits [1:0].
- issue_type  out  3  current issue for display.
- stall_count  out  CNT_W  saturating count of non-EXECUTE cycles.

Function
REQ-008 SHALL update all registered outputs on the falling edge of clk.
REQ-009 SHALL implement states IDLE, EXECUTE, HAZARD, INTERRUPT; IDLE moves to EXECUTE on the first edge after reset.
REQ-010 SHALL compute ex_conflict/mem_conflict as: write enabled, not no_op, dest index nonzero, and matching a valid source index.
REQ-011 SHALL flag data hazard = (branch_instruction & (ex_conflict | mem_conflict)) | (ex_mem_read_enable & ex_conflict).
REQ-012 SHALL flag UART hazard when pc_next > PC_MAX (unsigned compare, pc_next zero-extended or truncated to ISA_W).
REQ-013 In EXECUTE, priority SHALL be data > pause > UART > IRQ.
REQ-014 Data hazard SHALL set stages 0..1 HOLD, stage 2 NO_OP, issue DATA, go HAZARD; release when the hazard clears, restoring those stages to NORMAL.
REQ-015 Pause or UART hazard SHALL set stage 0 NO_OP, uart_disable=0, issue PAUSE or UART, go HAZARD.
REQ-016 UART issue SHALL resolve on uart_complete; PAUSE SHALL resolve on uart_complete with cpu_pause low; cpu_pause during UART upgrades issue to PAUSE.
REQ-017 UART/PAUSE resolution SHALL set uart_disable=1, stage 0 NORMAL, pulse pc_reset for exactly one cycle, go EXECUTE.
REQ-018 Any irq_req bit SHALL latch the lowest-index requester into irq_active, set all stages NO_OP, issue IRQ, go INTERRUPT.
REQ-019 INTERRUPT SHALL exit only on irq_done of the active source; irq_done of other sources is ignored; all stages return NORMAL, irq_active clears.
REQ-020 A request still asserted on exit SHALL be serviced again from EXECUTE no earlier than the next cycle.
REQ-021 stall_count SHALL increment each cycle state is not EXECUTE/IDLE and hold at all-ones.
REQ-022 Issue encodings SHALL be NONE=0, DATA=1, PAUSE=2, UART=3, IRQ=4.

Reset
REQ-023 rst SHALL immediately force IDLE, issue NONE, uart_disable=1, pc_reset=0, hazard_control all NORMAL, irq_active=0, stall_count=0, including mid-hazard or mid-interrupt.

Structure
REQ-024 Stage control codes (NORMAL, HOLD, NO_OP), issue codes, state codes and PC_MAX_VALUE SHALL live in the shared definitions package.
REQ-025 A sub-module irq_priority_encoder (IRQ_CNT-bit request to one-hot grant) SHALL be used.

Verification
REQ-026 EX load writing r5, ID reads r5 -> one HAZARD cycle, control {…,NO_OP,HOLD,HOLD}, issue DATA, then NORMAL.
REQ-027 EX writes r0, ID reads r0, branch=1 -> no stall, issue stays NONE.
REQ-028 pc_next=PC_MAX+4 -> issue UART, uart_disable=0; uart_complete -> pc_reset one cycle, uart_disable=1, EXECUTE.
REQ-029 irq_req=2'b11 -> irq_active=01, all NO_OP; irq_done=10 ignored; irq_done=01 -> exit, then irq_active=10 next service.
REQ-030 cpu_pause during UART, then uart_complete with pause high -> stays PAUSE; pause low -> resume.
REQ-031 rst asserted in INTERRUPT with CNT_W=4 after 20 stall cycles -> stall_count was 15, all outputs at reset values.
